bp_mcore_loop_dispatcher: RTL and testbench
===========================================

# bp_mcore_loop_dispatcher

Dynamic iteration scheduler for the multi-core HW looper. Software programs a global loop range [start, end) and a chunk size. Cores then request work over per-core request lines. The block shares the range among `num_core_p` requesters with round-robin arbitration and hands out disjoint chunks. Once the range is exhausted, it tells every core the loop is done. It sits beside the looper's memory-mapped register file, which drives its cfg inputs.

## Interface
- `num_core_p`, default 2: number of requesting cores.
- `dword_width_p`, default 64: width of indices and chunk size.
- `core_id_width_lp`, default `$clog2(num_core_p)` (1 if `num_core_p`=1): width of the grant id.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `reset_n_i`  in  1  reset; synchronous, active-low.
- `cfg_v_i`  in  1  load a new loop; accepted only when `cfg_ready_o`=1.
- `cfg_ready_o`  out  1  high in IDLE only.
- `cfg_start_i`  in  `dword_width_p`  global start index (inclusive).
- `cfg_end_i`  in  `dword_width_p`  global end index (exclusive).
- `cfg_chunk_i`  in  `dword_width_p`  iterations per grant; 0 is treated as 1.
- `req_v_i`  in  `num_core_p`  per-core level request for the next chunk.
- `grant_v_o`  out  1  grant valid; held until `grant_yumi_i`.
- `grant_id_o`  out  `core_id_width_lp`  core being granted.
- `grant_start_o`  out  `dword_width_p`  chunk start.
- `grant_end_o`  out  `dword_width_p`  chunk end (exclusive).
- `grant_done_o`  out  1  range exhausted; `grant_start_o`=`grant_end_o`=global end.
- `grant_yumi_i`  in  1  the granted core consumes the grant.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  one-cycle pulse: every core has received a done grant.

## Operation
- State machine:
  - IDLE: `cfg_ready_o`=1. On `cfg_v_i`, latch start into next_idx, latch end and chunk (max(chunk,1)), clear done_mask, go to RUN.
  - RUN: if any `req_v_i` bit is set, round-robin pick core c, register the grant fields, go to GRANT. Otherwise stay.
  - GRANT: hold all grant outputs stable until `grant_yumi_i`. On yumi:
    - Not done: next_idx <= grant_end.
    - Done: set done_mask[c].
    - Advance the rr pointer to c+1 mod `num_core_p`.
    - If done_mask becomes all-ones, go to COMPLETE; else go to RUN.
  - COMPLETE: `done_o`=1 for this cycle, then IDLE.
- Chunk arithmetic, computed at width `dword_width_p`+1:
  - sum = next_idx + chunk.
  - grant_end = (sum ≥ end) ? end : sum[dword_width_p-1:0]. This saturates, so there is no wrap-around.
- Done condition: next_idx ≥ end (unsigned). This covers an empty loop (start ≥ end): every request gets a done grant.
- A core that already holds done may request again. It gets another done grant and done_mask is unchanged.
- Requests from different cores are never merged. Exactly one grant is outstanding at a time.
- Requesters must drop or re-raise `req_v_i` after yumi. The block samples requests only in RUN.
- `cfg_v_i` outside IDLE is ignored.
- Reset values: state=IDLE, next_idx=0, end=0, chunk=1, done_mask=0, rr pointer=0. Outputs: `cfg_ready_o`=1, `grant_v_o`=0, `grant_id_o`=0, `grant_start_o`=0, `grant_end_o`=0, `grant_done_o`=0, `busy_o`=0, `done_o`=0.

## Timing
- cfg handshake at cycle N; `busy_o`=1 from N+1.
- Request seen in RUN at cycle M; `grant_v_o`=1 at M+1 with all fields registered. There is no combinational path from `req_v_i` to the grant outputs.
- Yumi at cycle K; RUN at K+1. Maximum throughput is one grant per 2 cycles.
- Last done yumi at K; `done_o`=1 at K+1; `cfg_ready_o`=1 at K+2.
- `grant_yumi_i` while `grant_v_o`=0 is ignored.
- Reset asserted mid-grant: outputs reach reset values on the next edge, and the pending grant is discarded.

## Structure
- Add to bp_common_pkg: typedef `bp_mlooper_disp_state_e` {e_idle, e_run, e_grant, e_complete}.
- Sub-module: `bsg_arb_round_robin` (width `num_core_p`). Its yumi_i is driven by `grant_v_o` & `grant_yumi_i`, so the pointer advances only on accepted grants.
- The chunk adder and saturation compare stay inline. The grant fields use a `bsg_dff_en` bank enabled on the RUN→GRANT transition.

## Test plan
- Basic split: start=0, end=10, chunk=4, core0 requesting. Grants [0,4), [4,8), [8,10), then done; `done_o` only after core1 also receives a done grant.
- Fairness: both cores requesting continuously, start=0, end=12, chunk=3. Grant ids 0,1,0,1 with chunks [0,3),[3,6),[6,9),[9,12); next grants are done to 0 then 1; `done_o` pulses once.
- Empty and zero-chunk cases:
  - start=5, end=5: the first request per core gets a done grant with start=end=5.
  - start=0, end=3, chunk=0: chunks of 1.
- Saturation: start=2^64-3, end=2^64-1, chunk=8. Single grant [2^64-3, 2^64-1), no wrap.
- Backpressure: hold `grant_yumi_i`=0 for 5 cycles. All grant fields are stable, and `cfg_v_i` is ignored while `busy_o`=1.
- Reset mid-operation: drive `reset_n_i`=0 during GRANT. Next cycle `grant_v_o`=0 and `cfg_ready_o`=1; a new cfg restarts from its new start.

Source files
------------

// File: rtl/bp_mcore_loop_dispatcher_pkg.sv
// Shared types for the multi-core loop dispatcher.
package bp_mcore_loop_dispatcher_pkg;

  typedef enum logic [1:0] {
    e_idle     = 2'd0,
    e_run      = 2'd1,
    e_grant    = 2'd2,
    e_complete = 2'd3
  } bp_mlooper_disp_state_e;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin requester picker. The pointer moves past a core only when that
// core's grant is actually consumed, so an unaccepted grant costs no fairness.
module bsg_arb_round_robin #(
  parameter int width_p    = 2,
  parameter int id_width_p = (width_p == 1) ? 1 : $clog2(width_p)
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [width_p-1:0]    reqs_i,
  input  logic                  yumi_i,
  input  logic [id_width_p-1:0] yumi_id_i,
  output logic                  v_o,
  output logic [id_width_p-1:0] id_o
);

  logic [id_width_p-1:0] r_ptr;
  logic [id_width_p-1:0] w_cand;

  // (ptr + k) mod width_p for k < width_p needs at most one subtraction
  function automatic logic [id_width_p-1:0] f_wrap(input logic [id_width_p:0] s);
    logic [id_width_p:0] t;
    t = (s >= (id_width_p+1)'(width_p)) ? s - (id_width_p+1)'(width_p) : s;
    return t[id_width_p-1:0];
  endfunction

  // Scan from the pointer downward so the candidate closest to the pointer wins
  always_comb begin
    v_o    = 1'b0;
    id_o   = r_ptr;
    w_cand = '0;
    for (int k = width_p - 1; k >= 0; k--) begin
      w_cand = f_wrap({1'b0, r_ptr} + (id_width_p+1)'(k));
      if (reqs_i[w_cand]) begin
        v_o  = 1'b1;
        id_o = w_cand;
      end
    end
  end

  // Pointer advances to the core after the one whose grant was consumed
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)  r_ptr <= '0;
    else if (yumi_i) r_ptr <= f_wrap({1'b0, yumi_id_i} + (id_width_p+1)'(1));
  end

endmodule

// File: rtl/bsg_dff_en.sv
// Enabled register bank with synchronous active-low clear.
module bsg_dff_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] r_data;

  // Capture on enable; clear on reset so a discarded grant leaves no residue
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_data <= '0;
    else if (en_i)  r_data <= data_i;
  end

  assign data_o = r_data;

endmodule

// File: rtl/bp_mcore_loop_dispatcher.sv
// Dynamic loop-iteration scheduler: shares [start,end) among cores in chunks,
// one outstanding grant at a time, then hands every core a done grant.
module bp_mcore_loop_dispatcher
  import bp_mcore_loop_dispatcher_pkg::*;
#(
  parameter int num_core_p       = 2,
  parameter int dword_width_p    = 64,
  parameter int core_id_width_lp = (num_core_p == 1) ? 1 : $clog2(num_core_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        cfg_v_i,
  output logic                        cfg_ready_o,
  input  logic [dword_width_p-1:0]    cfg_start_i,
  input  logic [dword_width_p-1:0]    cfg_end_i,
  input  logic [dword_width_p-1:0]    cfg_chunk_i,
  input  logic [num_core_p-1:0]       req_v_i,
  output logic                        grant_v_o,
  output logic [core_id_width_lp-1:0] grant_id_o,
  output logic [dword_width_p-1:0]    grant_start_o,
  output logic [dword_width_p-1:0]    grant_end_o,
  output logic                        grant_done_o,
  input  logic                        grant_yumi_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int W  = dword_width_p;
  localparam int FW = core_id_width_lp + 2 * W + 1;

  bp_mlooper_disp_state_e r_state;
  logic [W-1:0]           r_next_idx, r_end, r_chunk;
  logic [num_core_p-1:0]  r_done_mask;
  logic                   r_cfg_ready, r_grant_v, r_busy, r_done;

  logic                        w_arb_v;
  logic [core_id_width_lp-1:0] w_arb_id;
  logic [W:0]                  w_sum;
  logic                        w_is_done;
  logic [W-1:0]                w_g_start, w_g_end, w_cfg_chunk;
  logic                        w_latch, w_yumi;
  logic [num_core_p-1:0]       w_done_onehot, w_mask_nxt;
  logic [FW-1:0]               w_grant_q;

  // Chunk arithmetic one bit wide so the end index saturates instead of wrapping
  assign w_sum       = {1'b0, r_next_idx} + {1'b0, r_chunk};
  assign w_is_done   = (r_next_idx >= r_end);
  assign w_g_start   = w_is_done ? r_end : r_next_idx;
  assign w_g_end     = (w_is_done || (w_sum >= {1'b0, r_end})) ? r_end : w_sum[W-1:0];
  assign w_cfg_chunk = (cfg_chunk_i == '0) ? W'(1) : cfg_chunk_i;

  assign w_latch = (r_state == e_run) && w_arb_v;
  assign w_yumi  = r_grant_v && grant_yumi_i;

  bsg_arb_round_robin #(
    .width_p   (num_core_p),
    .id_width_p(core_id_width_lp)
  ) u_arb (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .reqs_i   (req_v_i),
    .yumi_i   (w_yumi),
    .yumi_id_i(grant_id_o),
    .v_o      (w_arb_v),
    .id_o     (w_arb_id)
  );

  bsg_dff_en #(.width_p(FW)) u_grant_q (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .en_i     (w_latch),
    .data_i   ({w_arb_id, w_g_start, w_g_end, w_is_done}),
    .data_o   (w_grant_q)
  );

  assign {grant_id_o, grant_start_o, grant_end_o, grant_done_o} = w_grant_q;

  // Done-mask update for the core currently holding the grant
  always_comb begin
    w_done_onehot             = '0;
    w_done_onehot[grant_id_o] = 1'b1;
    w_mask_nxt                = grant_done_o ? (r_done_mask | w_done_onehot) : r_done_mask;
  end

  // Dispatcher FSM with registered status outputs
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= e_idle;
      r_next_idx  <= '0;
      r_end       <= '0;
      r_chunk     <= W'(1);
      r_done_mask <= '0;
      r_cfg_ready <= 1'b1;
      r_grant_v   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        e_idle: if (cfg_v_i) begin
          r_next_idx  <= cfg_start_i;
          r_end       <= cfg_end_i;
          r_chunk     <= w_cfg_chunk;
          r_done_mask <= '0;
          r_cfg_ready <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= e_run;
        end
        e_run: if (w_arb_v) begin
          r_grant_v <= 1'b1;
          r_state   <= e_grant;
        end
        e_grant: if (grant_yumi_i) begin
          if (!grant_done_o) r_next_idx <= grant_end_o;
          r_done_mask <= w_mask_nxt;
          r_grant_v   <= 1'b0;
          if (&w_mask_nxt) begin
            r_done  <= 1'b1;
            r_state <= e_complete;
          end else begin
            r_state <= e_run;
          end
        end
        e_complete: begin
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= e_idle;
        end
        default: r_state <= e_idle;
      endcase
    end
  end

  assign cfg_ready_o = r_cfg_ready;
  assign grant_v_o   = r_grant_v;
  assign busy_o      = r_busy;
  assign done_o      = r_done;

endmodule

// File: tb/tb_bp_mcore_loop_dispatcher.sv
// Self-checking bench: directed grant tables, hand-written corner sequences,
// and randomized loops against a chunk-list reference model.
module tb_bp_mcore_loop_dispatcher;

  localparam int N    = 2;
  localparam int W    = 64;
  localparam int ID_W = 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            cfg_v;
  logic [W-1:0]    cfg_start, cfg_end, cfg_chunk;
  logic [N-1:0]    req_v;
  logic            grant_yumi;
  logic            cfg_ready_o, grant_v_o, grant_done_o, busy_o, done_o;
  logic [ID_W-1:0] grant_id_o;
  logic [W-1:0]    grant_start_o, grant_end_o;

  int n_cmp  = 0;
  int n_fail = 0;

  bp_mcore_loop_dispatcher #(.num_core_p(N), .dword_width_p(W)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .cfg_v_i      (cfg_v),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_start_i  (cfg_start),
    .cfg_end_i    (cfg_end),
    .cfg_chunk_i  (cfg_chunk),
    .req_v_i      (req_v),
    .grant_v_o    (grant_v_o),
    .grant_id_o   (grant_id_o),
    .grant_start_o(grant_start_o),
    .grant_end_o  (grant_end_o),
    .grant_done_o (grant_done_o),
    .grant_yumi_i (grant_yumi),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_cfg;
    logic [W-1:0] s, e, c;
    logic [N-1:0] req;
    int           id;
    logic [W-1:0] gs, ge;
    bit           gd, dn;
  } vec_t;

  typedef struct {
    logic [W-1:0] gs, ge;
  } chunk_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic addc(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] c);
    vec_t v;
    v = '{is_cfg: 1'b1, s: s, e: e, c: c, req: '0, id: 0, gs: '0, ge: '0, gd: 1'b0, dn: 1'b0};
    tbl.push_back(v);
  endtask

  task automatic adds(input logic [N-1:0] req, input int id, input logic [W-1:0] gs,
                      input logic [W-1:0] ge, input bit gd, input bit dn);
    vec_t v;
    v = '{is_cfg: 1'b0, s: '0, e: '0, c: '0, req: req, id: id, gs: gs, ge: ge, gd: gd, dn: dn};
    tbl.push_back(v);
  endtask

  // Called just after a falling edge; returns just after a falling edge
  task automatic do_cfg(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] c);
    int t;
    t = 0;
    while (!cfg_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("cfg_ready_wait", W'(cfg_ready_o), W'(1));
    cfg_v = 1'b1; cfg_start = s; cfg_end = e; cfg_chunk = c;
    @(negedge clk);
    cfg_v = 1'b0;
    chk("busy_after_cfg", W'(busy_o), W'(1));
    chk("cfg_ready_after_cfg", W'(cfg_ready_o), W'(0));
  endtask

  // One request/grant/yumi round; expects the block to be in RUN on entry
  task automatic grant_step(input logic [N-1:0] req, input int id, input logic [W-1:0] gs,
                            input logic [W-1:0] ge, input bit gd, input bit dn, input int hold);
    int t;
    req_v = req;
    @(negedge clk);
    t = 1;
    while (!grant_v_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    req_v = '0;
    chk("grant_v", W'(grant_v_o), W'(1));
    chk("grant_latency", W'(t), W'(1));
    chk("grant_id", W'(grant_id_o), W'(id));
    chk("grant_start", grant_start_o, gs);
    chk("grant_end", grant_end_o, ge);
    chk("grant_done", W'(grant_done_o), W'(gd));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_v", W'(grant_v_o), W'(1));
      chk("hold_start", grant_start_o, gs);
    end
    grant_yumi = 1'b1;
    @(negedge clk);
    grant_yumi = 1'b0;
    chk("grant_v_after_yumi", W'(grant_v_o), W'(0));
    chk("done_o", W'(done_o), W'(dn));
    if (dn) begin
      @(negedge clk);
      chk("done_o_pulse", W'(done_o), W'(0));
      chk("cfg_ready_after_done", W'(cfg_ready_o), W'(1));
      chk("busy_after_done", W'(busy_o), W'(0));
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [W-1:0] MAXV = {W{1'b1}};

  initial begin
    reset_n = 1'b0; cfg_v = 1'b0; cfg_start = '0; cfg_end = '0; cfg_chunk = '0;
    req_v = '0; grant_yumi = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cfg_ready", W'(cfg_ready_o), W'(1));
    chk("rst_grant_v", W'(grant_v_o), W'(0));
    chk("rst_grant_id", W'(grant_id_o), W'(0));
    chk("rst_grant_start", grant_start_o, '0);
    chk("rst_grant_end", grant_end_o, '0);
    chk("rst_grant_done", W'(grant_done_o), W'(0));
    chk("rst_busy", W'(busy_o), W'(0));
    chk("rst_done", W'(done_o), W'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Yumi with no grant outstanding must do nothing
    grant_yumi = 1'b1;
    @(negedge clk);
    grant_yumi = 1'b0;
    chk("idle_yumi_ready", W'(cfg_ready_o), W'(1));

    // Basic split, including a repeat done request from core 0
    addc(0, 10, 4);
    adds(2'b01, 0, 0, 4, 0, 0);
    adds(2'b01, 0, 4, 8, 0, 0);
    adds(2'b01, 0, 8, 10, 0, 0);
    adds(2'b01, 0, 10, 10, 1, 0);
    adds(2'b01, 0, 10, 10, 1, 0);
    adds(2'b10, 1, 10, 10, 1, 1);
    // Fairness
    addc(0, 12, 3);
    adds(2'b11, 0, 0, 3, 0, 0);
    adds(2'b11, 1, 3, 6, 0, 0);
    adds(2'b11, 0, 6, 9, 0, 0);
    adds(2'b11, 1, 9, 12, 0, 0);
    adds(2'b11, 0, 12, 12, 1, 0);
    adds(2'b11, 1, 12, 12, 1, 1);
    // Empty range
    addc(5, 5, 2);
    adds(2'b01, 0, 5, 5, 1, 0);
    adds(2'b10, 1, 5, 5, 1, 1);
    // Zero chunk acts as chunk 1
    addc(0, 3, 0);
    adds(2'b11, 0, 0, 1, 0, 0);
    adds(2'b11, 1, 1, 2, 0, 0);
    adds(2'b11, 0, 2, 3, 0, 0);
    adds(2'b11, 1, 3, 3, 1, 0);
    adds(2'b11, 0, 3, 3, 1, 1);
    // Saturation near the top of the index space
    addc(MAXV - 2, MAXV, 8);
    adds(2'b01, 0, MAXV - 2, MAXV, 0, 0);
    adds(2'b01, 0, MAXV, MAXV, 1, 0);
    adds(2'b10, 1, MAXV, MAXV, 1, 1);

    foreach (tbl[i]) begin
      if (tbl[i].is_cfg) do_cfg(tbl[i].s, tbl[i].e, tbl[i].c);
      else grant_step(tbl[i].req, tbl[i].id, tbl[i].gs, tbl[i].ge, tbl[i].gd, tbl[i].dn, 0);
    end

    // Backpressure: grant held for 5 cycles while a cfg is attempted
    do_cfg(100, 200, 7);
    req_v = 2'b01;
    @(negedge clk);
    req_v = '0;
    chk("bp_grant_v", W'(grant_v_o), W'(1));
    for (int k = 0; k < 5; k++) begin
      cfg_v = 1'b1; cfg_start = 0; cfg_end = 1; cfg_chunk = 1;
      @(negedge clk);
      chk("bp_v", W'(grant_v_o), W'(1));
      chk("bp_id", W'(grant_id_o), W'(0));
      chk("bp_start", grant_start_o, 100);
      chk("bp_end", grant_end_o, 107);
      chk("bp_done", W'(grant_done_o), W'(0));
      chk("bp_busy", W'(busy_o), W'(1));
      chk("bp_cfg_ready", W'(cfg_ready_o), W'(0));
    end
    cfg_v = 1'b0;
    grant_yumi = 1'b1;
    @(negedge clk);
    grant_yumi = 1'b0;
    grant_step(2'b10, 1, 107, 114, 0, 0, 0);

    // Reset while a grant is outstanding
    req_v = 2'b01;
    @(negedge clk);
    req_v = '0;
    chk("pre_rst_grant_v", W'(grant_v_o), W'(1));
    chk("pre_rst_start", grant_start_o, 114);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_grant_v", W'(grant_v_o), W'(0));
    chk("mid_rst_cfg_ready", W'(cfg_ready_o), W'(1));
    chk("mid_rst_busy", W'(busy_o), W'(0));
    chk("mid_rst_start", grant_start_o, '0);
    chk("mid_rst_end", grant_end_o, '0);
    reset_n = 1'b1;
    @(negedge clk);
    do_cfg(50, 60, 4);
    grant_yumi = 1'b1;
    @(negedge clk);
    grant_yumi = 1'b0;
    grant_step(2'b01, 0, 50, 54, 0, 0, 0);
    do_reset();

    // Randomized loops against a precomputed chunk list
    begin
      int     mptr;
      mptr = 0;
      for (int it = 0; it < 25; it++) begin
        logic [W-1:0] s, e, c, ce;
        logic [W:0]   i, hi;
        chunk_t       q[$];
        chunk_t       ch;
        logic [N-1:0] dm, req;
        int           id, steps;
        bit           gd;
        logic [W-1:0] gs, ge;
        s = W'($urandom_range(10, 60));
        e = ($urandom_range(0, 4) == 0) ? s - W'($urandom_range(0, 8))
                                        : s + W'($urandom_range(0, 30));
        c = W'($urandom_range(0, 9));
        ce = (c == 0) ? W'(1) : c;
        q.delete();
        i = {1'b0, s};
        while (i < {1'b0, e}) begin
          hi = i + {1'b0, ce};
          ch.gs = i[W-1:0];
          ch.ge = (hi > {1'b0, e}) ? e : hi[W-1:0];
          q.push_back(ch);
          i = hi;
        end
        do_cfg(s, e, c);
        dm = '0;
        steps = 0;
        while (dm != {N{1'b1}} && steps < 200) begin
          req = N'($urandom_range(1, (1 << N) - 1));
          id = mptr;
          for (int k = N - 1; k >= 0; k--)
            if (req[(mptr + k) % N]) id = (mptr + k) % N;
          if (q.size() > 0) begin
            ch = q.pop_front();
            gs = ch.gs; ge = ch.ge; gd = 1'b0;
          end else begin
            gs = e; ge = e; gd = 1'b1;
            dm[id] = 1'b1;
          end
          mptr = (id + 1) % N;
          grant_step(req, id, gs, ge, gd, dm == {N{1'b1}}, int'($urandom_range(0, 2)));
          steps++;
        end
        chk("rand_loop_bounded", W'(steps < 200), W'(1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
